// File: rtl/vram_arbiter.sv
// Two-master Avalon-MM arbiter for a shared video-RAM slave port.
// Master 0 (pixel reader) has priority; master 1 is guaranteed a grant after M0_BURST_MAX master-0 wins.
module vram_arbiter #(
    parameter int ADDR_W       = 20,
    parameter int DATA_W       = 16,
    parameter int M0_BURST_MAX = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_waitrequest,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_waitrequest,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_waitrequest,
    output logic [1:0]          grant
);

    localparam int CNT_W = $clog2(M0_BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(M0_BURST_MAX);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
    logic             req0, req1;

    assign req0 = m0_read;
    assign req1 = m1_read | m1_write;

    // Read data is broadcast; only the owner's copy carries meaning.
    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        s_read         = 1'b0;
        s_write        = 1'b0;
        grant          = 2'b00;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        s_address      = m0_address;
        s_writedata    = m1_writedata;
        s_byteenable   = '1;

        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    if (starve_cnt < CNT_MAX) begin
                        state_nxt      = OWN0;
                        starve_cnt_nxt = starve_cnt + 1'b1;
                    end else begin
                        state_nxt      = OWN1;
                        starve_cnt_nxt = '0;
                    end
                end else if (req1) begin
                    state_nxt      = OWN1;
                    starve_cnt_nxt = '0;
                end else if (req0) begin
                    state_nxt = OWN0;
                end
            end
            OWN0: begin
                grant          = 2'b01;
                s_read         = m0_read;
                m0_waitrequest = s_waitrequest;
                // Either completion or the owner giving up returns to arbitration.
                if (!req0 || !s_waitrequest) begin
                    state_nxt = IDLE;
                end
            end
            OWN1: begin
                grant          = 2'b10;
                s_address      = m1_address;
                s_byteenable   = m1_byteenable;
                s_write        = m1_write;
                s_read         = m1_read & ~m1_write;
                m1_waitrequest = s_waitrequest;
                if (!req1 || !s_waitrequest) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Reset masks the bus immediately, before the state register clears.
        if (reset) begin
            s_read         = 1'b0;
            s_write        = 1'b0;
            grant          = 2'b00;
            m0_waitrequest = 1'b1;
            m1_waitrequest = 1'b1;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level owner/counter model of the arbitration rules.
module tb_vram_arbiter;

    localparam int ADDR_W       = 20;
    localparam int DATA_W       = 16;
    localparam int M0_BURST_MAX = 8;
    localparam int BE_W         = DATA_W / 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] m0_address = '0;
    logic              m0_read = 1'b0;
    logic [DATA_W-1:0] m0_readdata;
    logic              m0_waitrequest;
    logic [ADDR_W-1:0] m1_address = '0;
    logic              m1_read = 1'b0;
    logic              m1_write = 1'b0;
    logic [DATA_W-1:0] m1_writedata = '0;
    logic [BE_W-1:0]   m1_byteenable = '0;
    logic [DATA_W-1:0] m1_readdata;
    logic              m1_waitrequest;
    logic [ADDR_W-1:0] s_address;
    logic              s_read;
    logic              s_write;
    logic [DATA_W-1:0] s_writedata;
    logic [BE_W-1:0]   s_byteenable;
    logic [DATA_W-1:0] s_readdata = '0;
    logic              s_waitrequest = 1'b0;
    logic [1:0]        grant;

    always #5 clk = ~clk;

    vram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .M0_BURST_MAX(M0_BURST_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read),
        .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
        .grant(grant)
    );

    int checks = 0;
    int failures = 0;

    // Model: who owns the slave (0 none, 1 master 0, 2 master 1) and how many
    // times master 0 has beaten a waiting master 1.
    int owner = 0;
    int wins0 = 0;
    bit done0, done1;

    // Values sampled mid-cycle by the last call to cycle().
    logic              obs_sread, obs_swrite, obs_w0;
    logic [DATA_W-1:0] obs_rd0, obs_wd;
    logic [BE_W-1:0]   obs_be;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        logic er, ew, ew0, ew1;
        logic [1:0] eg;
        @(negedge clk);
        er = 1'b0; ew = 1'b0; eg = 2'b00; ew0 = 1'b1; ew1 = 1'b1;
        if (!reset) begin
            if (owner == 1) begin
                er = m0_read; eg = 2'b01; ew0 = s_waitrequest;
            end else if (owner == 2) begin
                ew = m1_write; er = m1_read && !m1_write; eg = 2'b10; ew1 = s_waitrequest;
            end
        end
        check_eq("s_read", s_read, er);
        check_eq("s_write", s_write, ew);
        check_eq("grant", grant, eg);
        check_eq("m0_wait", m0_waitrequest, ew0);
        check_eq("m1_wait", m1_waitrequest, ew1);
        check_eq("m0_rdata", m0_readdata, s_readdata);
        check_eq("m1_rdata", m1_readdata, s_readdata);
        if (er || ew) begin
            check_eq("s_addr", s_address, (owner == 1) ? m0_address : m1_address);
            check_eq("s_be", s_byteenable, (owner == 1) ? {BE_W{1'b1}} : m1_byteenable);
        end
        if (ew) check_eq("s_wdata", s_writedata, m1_writedata);
        obs_sread = s_read; obs_swrite = s_write; obs_w0 = m0_waitrequest;
        obs_rd0 = m0_readdata; obs_wd = s_writedata; obs_be = s_byteenable;

        @(posedge clk);
        done0 = 1'b0; done1 = 1'b0;
        if (reset) begin
            owner = 0; wins0 = 0;
        end else if (owner == 0) begin
            if (m0_read && (m1_read || m1_write)) begin
                if (wins0 < M0_BURST_MAX) begin owner = 1; wins0 = wins0 + 1; end
                else begin owner = 2; wins0 = 0; end
            end else if (m1_read || m1_write) begin
                owner = 2; wins0 = 0;
            end else if (m0_read) begin
                owner = 1;
            end
        end else if (owner == 1) begin
            if (!m0_read) owner = 0;
            else if (!s_waitrequest) begin owner = 0; done0 = 1'b1; end
        end else begin
            if (!(m1_read || m1_write)) owner = 0;
            else if (!s_waitrequest) begin owner = 0; done1 = 1'b1; end
        end
        #1;
    endtask

    task automatic idle_inputs();
        m0_read = 1'b0; m1_read = 1'b0; m1_write = 1'b0; s_waitrequest = 1'b0;
    endtask

    initial begin
        int run0, own1_seen, ack_cnt;
        logic [1:0] prev_g;
        #1;
        // Reset held two cycles with master 0 already requesting.
        reset = 1'b1; m0_read = 1'b1; m0_address = 20'h00010;
        cycle();
        check_eq("t1_sread", obs_sread, 1'b0);
        check_eq("t1_wait0", obs_w0, 1'b1);
        cycle();
        reset = 1'b0;
        cycle();
        check_eq("t1_grant", grant, 2'b01);

        // Slave stalls twice, then returns 0x07E0.
        s_waitrequest = 1'b1; s_readdata = 16'h07E0;
        ack_cnt = 0;
        cycle(); if (obs_w0 == 1'b0) ack_cnt++;
        cycle(); if (obs_w0 == 1'b0) ack_cnt++;
        s_waitrequest = 1'b0;
        cycle(); if (obs_w0 == 1'b0) ack_cnt++;
        check_eq("t2_rdata", obs_rd0, 16'h07E0);
        m0_read = 1'b0;
        check_eq("t2_grant_idle", grant, 2'b00);
        cycle(); if (obs_w0 == 1'b0) ack_cnt++;
        check_eq("t2_acks", ack_cnt, 1);

        // Both masters saturating a zero-wait slave.
        reset = 1'b1; cycle(); reset = 1'b0;
        m0_read = 1'b1; m1_read = 1'b1; s_waitrequest = 1'b0;
        run0 = 0; own1_seen = 0; prev_g = 2'b00;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (grant == 2'b01 && prev_g != 2'b01) run0++;
            if (grant == 2'b10 && prev_g != 2'b10) begin
                check_eq("t3_burst", run0, M0_BURST_MAX);
                run0 = 0; own1_seen++;
            end
            prev_g = grant;
        end
        check_eq("t3_own1_count", own1_seen, 2);
        idle_inputs();
        cycle(); cycle();

        // Master 1 byte-lane write with master 0 idle.
        m1_write = 1'b1; m1_address = 20'h12345; m1_writedata = 16'hF800; m1_byteenable = 2'b10;
        cycle();
        cycle();
        check_eq("t4_swrite", obs_swrite, 1'b1);
        check_eq("t4_wdata", obs_wd, 16'hF800);
        check_eq("t4_be", obs_be, 2'b10);
        check_eq("t4_wait0", obs_w0, 1'b1);
        m1_write = 1'b0;
        cycle();

        // Master 1 aborts a stalled write while master 0 waits.
        m1_write = 1'b1;
        cycle();
        m0_read = 1'b1; s_waitrequest = 1'b1;
        cycle();
        m1_write = 1'b0;
        cycle();
        check_eq("t5_swrite", obs_swrite, 1'b0);
        check_eq("t5_grant_idle", grant, 2'b00);
        cycle();
        check_eq("t5_grant0", grant, 2'b01);

        // Reset in the middle of a stalled master-0 read.
        cycle();
        reset = 1'b1;
        cycle();
        check_eq("t6_sread", obs_sread, 1'b0);
        reset = 1'b0; m0_read = 1'b0; #1;
        check_eq("t6_grant_idle", grant, 2'b00);
        m1_read = 1'b1; m1_write = 1'b1; s_waitrequest = 1'b1;
        cycle();
        cycle();
        check_eq("t6_illegal_sread", obs_sread, 1'b0);
        check_eq("t6_illegal_swrite", obs_swrite, 1'b1);
        idle_inputs();
        cycle();

        // Random traffic with holds, aborts, stalls and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            if (!m0_read || done0) begin
                m0_read = ($urandom_range(0, 99) < 50);
                m0_address = ADDR_W'($urandom);
            end else if ($urandom_range(0, 99) < 3) begin
                m0_read = 1'b0;
            end
            if (!(m1_read || m1_write) || done1) begin
                int r;
                r = $urandom_range(0, 19);
                m1_read  = (r < 8) || (r == 19);
                m1_write = (r >= 8) && (r < 12) || (r == 19);
                m1_address = ADDR_W'($urandom);
                m1_writedata = DATA_W'($urandom);
                m1_byteenable = BE_W'($urandom);
            end else if ($urandom_range(0, 99) < 3) begin
                m1_read = 1'b0; m1_write = 1'b0;
            end
            s_waitrequest = ($urandom_range(0, 99) < 40);
            s_readdata = DATA_W'($urandom);
            reset = ($urandom_range(0, 99) < 1);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
